dp_ram_sync: RTL and testbench

Parametrised, synchronous-read, true dual-port RAM with per-byte write masks. It supersedes the fixed 512×32 asynchronous-read memory used for data/instruction storage in the core. The block adds:
- configurable width, depth and read latency;
- defined read-during-write and write-collision behaviour;
- a hardware clear sequencer that zeroes the array over DEPTH cycles instead of through a reset fan-out.

---
 rtl/dp_ram_sync.sv | 193 +++++++++++++++++++
 tb/tb_dp_ram_sync.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_sync.sv
// dp_ram_sync: true dual-port RAM with synchronous read, per-byte write masks,
// write-first read-during-write, byte-wise collision resolution and a
// hardware clear sequencer that zeroes the array one word per cycle.
module dp_ram_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1,
  parameter int PRIO_A = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_a,
  input  logic                  i_wren_a,
  input  logic [ADDR_W-1:0]     i_addr_a,
  input  logic [DATA_W-1:0]     i_wdata_a,
  input  logic [DATA_W/8-1:0]   i_bmask_a,
  output logic                  o_rvalid_a,
  output logic [DATA_W-1:0]     o_rdata_a,
  input  logic                  i_req_b,
  input  logic                  i_wren_b,
  input  logic [ADDR_W-1:0]     i_addr_b,
  input  logic [DATA_W-1:0]     i_wdata_b,
  input  logic [DATA_W/8-1:0]   i_bmask_b,
  output logic                  o_rvalid_b,
  output logic [DATA_W-1:0]     o_rdata_b,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_coll
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic                busy;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc_a, acc_b;
  logic                in_a, in_b;
  logic                same_addr;
  logic                wr_a_p0, wr_b_p0;
  logic                rd_a_p0, rd_b_p0;
  logic                coll_p0;
  logic [DATA_W-1:0]   old_a, old_b;
  logic [DATA_W-1:0]   new_a, new_b;

  logic                vld_a_p1, vld_b_p1;
  logic [DATA_W-1:0]   rdata_a_p1, rdata_b_p1;
  logic                coll_p1;

  // Final word at one address after this cycle's writes: each byte takes the
  // winning port's data where both masks hit, else the single writer, else old.
  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old,
    input logic              hit_a,
    input logic [DATA_W-1:0] data_a,
    input logic [NB-1:0]     mask_a,
    input logic              hit_b,
    input logic [DATA_W-1:0] data_b,
    input logic [NB-1:0]     mask_b
  );
    logic [DATA_W-1:0] word;
    word = old;
    for (int k = 0; k < NB; k++) begin
      if (hit_a && mask_a[k] && ((PRIO_A != 0) || !(hit_b && mask_b[k])))
        word[8*k +: 8] = data_a[8*k +: 8];
      else if (hit_b && mask_b[k])
        word[8*k +: 8] = data_b[8*k +: 8];
    end
    return word;
  endfunction

  // Clear sequencer: walks ptr over the whole array, then idles until i_clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        IDLE: begin
          if (i_clear) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Stage p0: request acceptance, range check, write-first merge, collision.
  always_comb begin
    acc_a     = i_req_a & ~busy;
    acc_b     = i_req_b & ~busy;
    in_a      = ({1'b0, i_addr_a} < DEPTH_V);
    in_b      = ({1'b0, i_addr_b} < DEPTH_V);
    same_addr = (i_addr_a == i_addr_b);
    wr_a_p0   = acc_a & i_wren_a & in_a;
    wr_b_p0   = acc_b & i_wren_b & in_b;
    rd_a_p0   = acc_a & ~i_wren_a;
    rd_b_p0   = acc_b & ~i_wren_b;
    old_a     = in_a ? mem[i_addr_a] : '0;
    old_b     = in_b ? mem[i_addr_b] : '0;
    new_a     = merge_word(old_a, wr_a_p0, i_wdata_a, i_bmask_a,
                           wr_b_p0 & same_addr, i_wdata_b, i_bmask_b);
    new_b     = merge_word(old_b, wr_a_p0 & same_addr, i_wdata_a, i_bmask_a,
                           wr_b_p0, i_wdata_b, i_bmask_b);
    coll_p0   = wr_a_p0 & wr_b_p0 & same_addr & (|(i_bmask_a & i_bmask_b));
  end

  // Array update: clear sequencer owns the array while busy, ports otherwise.
  always_ff @(posedge i_clk) begin
    if (busy) begin
      mem[ptr] <= '0;
    end else begin
      if (wr_a_p0) mem[i_addr_a] <= new_a;
      if (wr_b_p0) mem[i_addr_b] <= new_b;
    end
  end

  // Stage p1: registered read data (held between reads) and collision pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_a_p1   <= 1'b0;
      vld_b_p1   <= 1'b0;
      rdata_a_p1 <= '0;
      rdata_b_p1 <= '0;
      coll_p1    <= 1'b0;
    end else begin
      vld_a_p1 <= rd_a_p0;
      vld_b_p1 <= rd_b_p0;
      coll_p1  <= coll_p0;
      if (rd_a_p0) rdata_a_p1 <= new_a;
      if (rd_b_p0) rdata_b_p1 <= new_b;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              vld_a_p2, vld_b_p2;
      logic [DATA_W-1:0] rdata_a_p2, rdata_b_p2;

      // Stage p2: extra output register, loads only when p1 carries a result.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          vld_a_p2   <= 1'b0;
          vld_b_p2   <= 1'b0;
          rdata_a_p2 <= '0;
          rdata_b_p2 <= '0;
        end else begin
          vld_a_p2 <= vld_a_p1;
          vld_b_p2 <= vld_b_p1;
          if (vld_a_p1) rdata_a_p2 <= rdata_a_p1;
          if (vld_b_p1) rdata_b_p2 <= rdata_b_p1;
        end
      end

      assign o_rvalid_a = vld_a_p2;
      assign o_rvalid_b = vld_b_p2;
      assign o_rdata_a  = rdata_a_p2;
      assign o_rdata_b  = rdata_b_p2;
    end else begin : g_lat1
      assign o_rvalid_a = vld_a_p1;
      assign o_rvalid_b = vld_b_p1;
      assign o_rdata_a  = rdata_a_p1;
      assign o_rdata_b  = rdata_b_p1;
    end
  endgenerate

  assign o_busy = busy;
  assign o_coll = coll_p1;

endmodule

// File: tb/tb_dp_ram_sync.sv
// Bench for dp_ram_sync: two instances (512 words / latency 1 / port A wins,
// 300 words / latency 2 / port B wins) driven with identical stimulus. A
// word-array model predicts every output event (read result, collision pulse,
// busy cycle) tagged with its cycle number; the observed event list is
// compared against it after each scenario.
module tb_dp_ram_sync;

  typedef logic [63:0] ev_t;  // {tag[1:0], cycle[29:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, wren_a = 1'b0, req_b = 1'b0, wren_b = 1'b0, clear = 1'b0;
  logic [8:0]  addr_a = '0, addr_b = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;
  logic [3:0]  bmask_a = '0, bmask_b = '0;

  logic        rvalid_a0, rvalid_b0, busy0, coll0;
  logic        rvalid_a1, rvalid_b1, busy1, coll1;
  logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;

  always #5 clk = ~clk;

  dp_ram_sync #(.DATA_W(32), .DEPTH(512), .RD_LAT(1), .PRIO_A(1)) dut0 (
    .i_clk(clk), .i_reset(rst),
    .i_req_a(req_a), .i_wren_a(wren_a), .i_addr_a(addr_a), .i_wdata_a(wdata_a), .i_bmask_a(bmask_a),
    .o_rvalid_a(rvalid_a0), .o_rdata_a(rdata_a0),
    .i_req_b(req_b), .i_wren_b(wren_b), .i_addr_b(addr_b), .i_wdata_b(wdata_b), .i_bmask_b(bmask_b),
    .o_rvalid_b(rvalid_b0), .o_rdata_b(rdata_b0),
    .i_clear(clear), .o_busy(busy0), .o_coll(coll0));

  dp_ram_sync #(.DATA_W(32), .DEPTH(300), .RD_LAT(2), .PRIO_A(0)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_req_a(req_a), .i_wren_a(wren_a), .i_addr_a(addr_a), .i_wdata_a(wdata_a), .i_bmask_a(bmask_a),
    .o_rvalid_a(rvalid_a1), .o_rdata_a(rdata_a1),
    .i_req_b(req_b), .i_wren_b(wren_b), .i_addr_b(addr_b), .i_wdata_b(wdata_b), .i_bmask_b(bmask_b),
    .o_rvalid_b(rvalid_b1), .o_rdata_b(rdata_b1),
    .i_clear(clear), .o_busy(busy1), .o_coll(coll1));

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;

  // Reference model: plain word arrays plus a remaining-busy-cycles counter.
  logic [31:0] mm [2][512];
  int          cnt [2];
  int          dep_m [2] = '{512, 300};
  int          lat_m [2] = '{1, 2};
  bit          prio_m [2] = '{1'b1, 1'b0};

  ev_t exp0[$], exp1[$], obs0[$], obs1[$];
  ev_t got0, want0, got1, want1;

  // Record every output event of both instances.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rvalid_a0) obs0.push_back({2'd0, 30'(cyc), rdata_a0});
      if (rvalid_b0) obs0.push_back({2'd1, 30'(cyc), rdata_b0});
      if (coll0)     obs0.push_back({2'd2, 30'(cyc), 32'd0});
      if (busy0)     obs0.push_back({2'd3, 30'(cyc), 32'd0});
      if (rvalid_a1) obs1.push_back({2'd0, 30'(cyc), rdata_a1});
      if (rvalid_b1) obs1.push_back({2'd1, 30'(cyc), rdata_b1});
      if (coll1)     obs1.push_back({2'd2, 30'(cyc), 32'd0});
      if (busy1)     obs1.push_back({2'd3, 30'(cyc), 32'd0});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rd_model(input int d, input logic [8:0] a);
    return (int'(a) < dep_m[d]) ? mm[d][a] : 32'd0;
  endfunction

  function automatic void m_write(input int d, input logic [8:0] a, input logic [31:0] data,
                                  input logic [3:0] m);
    for (int k = 0; k < 4; k++)
      if (m[k]) mm[d][a][8*k +: 8] = data[8*k +: 8];
  endfunction

  function automatic void push_exp(input int d, input ev_t e);
    if (d == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endfunction

  // First position where the sorted event lists differ; both outputs 0 if equal.
  function automatic void qdiff(input ev_t a[$], input ev_t b[$], output ev_t ga, output ev_t gb);
    a.sort();
    b.sort();
    ga = '0;
    gb = '0;
    for (int i = 0; i < a.size() || i < b.size(); i++) begin
      ga = (i < a.size()) ? a[i] : 'x;
      gb = (i < b.size()) ? b[i] : 'x;
      if (ga !== gb) return;
    end
    ga = '0;
    gb = '0;
  endfunction

  function automatic void zero_model(input int d);
    for (int i = 0; i < 512; i++) mm[d][i] = 32'd0;
  endfunction

  // One clock cycle of stimulus; the model predicts the events it causes.
  task automatic step(input bit ra, input bit wa, input logic [8:0] aa, input logic [31:0] da,
                      input logic [3:0] ma, input bit rb, input bit wb, input logic [8:0] ab,
                      input logic [31:0] db, input logic [3:0] mb, input bit clr);
    bit clr_go [2];
    req_a = ra; wren_a = wa; addr_a = aa; wdata_a = da; bmask_a = ma;
    req_b = rb; wren_b = wb; addr_b = ab; wdata_b = db; bmask_b = mb;
    clear = clr;
    for (int d = 0; d < 2; d++) begin
      bit acc_a, acc_b, w_a, w_b;
      acc_a = ra && (cnt[d] == 0);
      acc_b = rb && (cnt[d] == 0);
      w_a = acc_a && wa && (int'(aa) < dep_m[d]);
      w_b = acc_b && wb && (int'(ab) < dep_m[d]);
      // the winning port is applied last so it owns every doubly-masked byte
      if (prio_m[d]) begin
        if (w_b) m_write(d, ab, db, mb);
        if (w_a) m_write(d, aa, da, ma);
      end else begin
        if (w_a) m_write(d, aa, da, ma);
        if (w_b) m_write(d, ab, db, mb);
      end
      if (acc_a && !wa) push_exp(d, {2'd0, 30'(cyc + lat_m[d]), rd_model(d, aa)});
      if (acc_b && !wb) push_exp(d, {2'd1, 30'(cyc + lat_m[d]), rd_model(d, ab)});
      if (w_a && w_b && aa == ab && (ma & mb) != 4'd0) push_exp(d, {2'd2, 30'(cyc + 1), 32'd0});
      clr_go[d] = clr && (cnt[d] == 0);
      if (clr_go[d]) zero_model(d);
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (cnt[d] > 0) cnt[d]--;
      else if (clr_go[d]) cnt[d] = dep_m[d];
      if (cnt[d] > 0) push_exp(d, {2'd3, 30'(cyc), 32'd0});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic wr_a(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    step(1, 1, a, d, m, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic rd_a(input logic [8:0] a);
    step(1, 0, a, '0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic reset_assert();
    mon_on = 1'b0;
    rst = 1'b1;
    req_a = 0; wren_a = 0; req_b = 0; wren_b = 0; clear = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_release();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = dep_m[d];
      zero_model(d);
    end
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
    #1 mon_on = 1'b1;
  endtask

  task automatic test_reset();
    reset_assert();
    n_chk++; if (busy0 !== 1'b1) $display("FAIL reset_busy0: got %b want 1", busy0); else n_pass++;
    n_chk++; if (busy1 !== 1'b1) $display("FAIL reset_busy1: got %b want 1", busy1); else n_pass++;
    n_chk++; if ({rvalid_a0, rvalid_b0, coll0} !== 3'b000)
      $display("FAIL reset_pulses0: got %b want 000", {rvalid_a0, rvalid_b0, coll0}); else n_pass++;
    n_chk++; if ({rvalid_a1, rvalid_b1, coll1} !== 3'b000)
      $display("FAIL reset_pulses1: got %b want 000", {rvalid_a1, rvalid_b1, coll1}); else n_pass++;
    n_chk++; if ({rdata_a0, rdata_b0} !== 64'd0)
      $display("FAIL reset_rdata0: got %h want 0", {rdata_a0, rdata_b0}); else n_pass++;
    n_chk++; if ({rdata_a1, rdata_b1} !== 64'd0)
      $display("FAIL reset_rdata1: got %h want 0", {rdata_a1, rdata_b1}); else n_pass++;
    reset_release();
    idle(515);
    rd_a(9'd0); rd_a(9'd255); rd_a(9'd511);
    idle(3);
    #1;
    qdiff(obs0, exp0, got0, want0);
    qdiff(obs1, exp1, got1, want1);
    n_chk++; if (got0 !== want0) $display("FAIL reset_clear dut0 event: got %h want %h", got0, want0); else n_pass++;
    n_chk++; if (got1 !== want1) $display("FAIL reset_clear dut1 event: got %h want %h", got1, want1); else n_pass++;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  task automatic test_byte_mask();
    wr_a(9'd5, 32'hAABBCCDD, 4'b1111);
    step(0, 0, '0, '0, '0, 1, 1, 9'd5, 32'h11223344, 4'b0101, 0);
    rd_a(9'd5);
    wr_a(9'd6, 32'hCAFEF00D, 4'b0000);
    step(0, 0, '0, '0, '0, 1, 0, 9'd6, '0, '0, 0);
    idle(3);
    #1;
    qdiff(obs0, exp0, got0, want0);
    qdiff(obs1, exp1, got1, want1);
    n_chk++; if (got0 !== want0) $display("FAIL byte_mask dut0 event: got %h want %h", got0, want0); else n_pass++;
    n_chk++; if (got1 !== want1) $display("FAIL byte_mask dut1 event: got %h want %h", got1, want1); else n_pass++;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  task automatic test_write_first();
    wr_a(9'd9, 32'h01020304, 4'b1111);
    step(1, 1, 9'd9, 32'hDEADBEEF, 4'b1100, 1, 0, 9'd9, '0, '0, 0);
    idle(3);
    #1;
    qdiff(obs0, exp0, got0, want0);
    qdiff(obs1, exp1, got1, want1);
    n_chk++; if (got0 !== want0) $display("FAIL write_first dut0 event: got %h want %h", got0, want0); else n_pass++;
    n_chk++; if (got1 !== want1) $display("FAIL write_first dut1 event: got %h want %h", got1, want1); else n_pass++;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  task automatic test_collision();
    step(1, 1, 9'd3, 32'hFFFFFFFF, 4'b1111, 1, 1, 9'd3, 32'h00000000, 4'b1111, 0);
    idle(1);
    rd_a(9'd3);
    step(1, 1, 9'd3, 32'hFFFFFFFF, 4'b0011, 1, 1, 9'd3, 32'h00000000, 4'b1100, 0);
    step(0, 0, '0, '0, '0, 1, 0, 9'd3, '0, '0, 0);
    step(1, 1, 9'd4, 32'h12345678, 4'b0110, 1, 1, 9'd4, 32'h9ABCDEF0, 4'b0011, 0);
    rd_a(9'd4);
    idle(3);
    #1;
    qdiff(obs0, exp0, got0, want0);
    qdiff(obs1, exp1, got1, want1);
    n_chk++; if (got0 !== want0) $display("FAIL collision dut0 event: got %h want %h", got0, want0); else n_pass++;
    n_chk++; if (got1 !== want1) $display("FAIL collision dut1 event: got %h want %h", got1, want1); else n_pass++;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  task automatic test_clear_gating();
    wr_a(9'd7, 32'h12345678, 4'b1111);
    step(1, 0, 9'd7, '0, '0, 0, 0, '0, '0, '0, 1);
    step(1, 1, 9'd7, 32'hFFFFFFFF, 4'b1111, 1, 0, 9'd7, '0, '0, 1);
    idle(515);
    rd_a(9'd7);
    idle(3);
    #1;
    qdiff(obs0, exp0, got0, want0);
    qdiff(obs1, exp1, got1, want1);
    n_chk++; if (got0 !== want0) $display("FAIL clear_gating dut0 event: got %h want %h", got0, want0); else n_pass++;
    n_chk++; if (got1 !== want1) $display("FAIL clear_gating dut1 event: got %h want %h", got1, want1); else n_pass++;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  task automatic test_reset_mid_clear();
    step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1);
    idle(100);
    #1;
    qdiff(obs0, exp0, got0, want0);
    qdiff(obs1, exp1, got1, want1);
    n_chk++; if (got0 !== want0) $display("FAIL partial_clear dut0 event: got %h want %h", got0, want0); else n_pass++;
    n_chk++; if (got1 !== want1) $display("FAIL partial_clear dut1 event: got %h want %h", got1, want1); else n_pass++;
    reset_assert();
    reset_release();
    idle(515);
    rd_a(9'd310);
    for (int i = 0; i < 4; i++) wr_a(9'(20 + i), $urandom, 4'b1111);
    for (int i = 0; i < 4; i++) rd_a(9'(20 + i));
    idle(4);
    #1;
    qdiff(obs0, exp0, got0, want0);
    qdiff(obs1, exp1, got1, want1);
    n_chk++; if (got0 !== want0) $display("FAIL mid_clear_b2b dut0 event: got %h want %h", got0, want0); else n_pass++;
    n_chk++; if (got1 !== want1) $display("FAIL mid_clear_b2b dut1 event: got %h want %h", got1, want1); else n_pass++;
    n_chk++; if (rdata_a0 !== mm[0][23]) $display("FAIL hold dut0: got %h want %h", rdata_a0, mm[0][23]); else n_pass++;
    n_chk++; if (rdata_a1 !== mm[1][23]) $display("FAIL hold dut1: got %h want %h", rdata_a1, mm[1][23]); else n_pass++;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [8:0] aa, ab;
      aa = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
      ab = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, aa, $urandom, 4'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ab, $urandom, 4'($urandom), 0);
    end
    idle(4);
    #1;
    qdiff(obs0, exp0, got0, want0);
    qdiff(obs1, exp1, got1, want1);
    n_chk++; if (got0 !== want0) $display("FAIL random dut0 event: got %h want %h", got0, want0); else n_pass++;
    n_chk++; if (got1 !== want1) $display("FAIL random dut1 event: got %h want %h", got1, want1); else n_pass++;
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  initial begin
    test_reset();
    test_byte_mask();
    test_write_first();
    test_collision();
    test_clear_gating();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
